// File: rtl/feature_mem_stream.sv
// feature_mem_stream
// Feature memory of DEPTH points x LENGTH features (DATA_WIDTH bits each),
// organised as {point, feature} rows. It has a single-word write port and a
// burst read engine. The engine streams whole consecutive points over a
// valid/ready interface with backpressure.
//
// Ports
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   wr_en/wr_pt/wr_feat/wr_data : single-word write, legal at any time
//   rd_req/rd_ready   : burst request handshake (rd_ready = engine idle)
//   rd_pt/rd_num      : first point and point count (0..DEPTH) of the burst
//   out_valid/out_ready : stream handshake
//   out_data/out_pt/out_feat/out_eop/out_last : stream word and metadata
module feature_mem_stream #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned LENGTH     = 16,
  parameter int unsigned PT_BITS    = 10,
  parameter int unsigned LEN_BITS   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [PT_BITS-1:0]    wr_pt,
  input  logic [LEN_BITS-1:0]   wr_feat,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_req,
  output logic                  rd_ready,
  input  logic [PT_BITS-1:0]    rd_pt,
  input  logic [PT_BITS:0]      rd_num,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [PT_BITS-1:0]    out_pt,
  output logic [LEN_BITS-1:0]   out_feat,
  output logic                  out_eop,
  output logic                  out_last
);

  localparam logic [LEN_BITS-1:0] FEAT_LAST = LEN_BITS'(LENGTH - 1);
  localparam logic [PT_BITS:0]    REM_ONE   = (PT_BITS+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [PT_BITS-1:0]    pt;
    logic [LEN_BITS-1:0]   feat;
    logic                  eop;
    logic                  last;
  } entry_t;

  // Storage and synchronous read port
  logic [DATA_WIDTH-1:0] mem_q [DEPTH*LENGTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Engine state
  state_e               state_q, state_d;
  logic [PT_BITS-1:0]   pt_q, pt_d;
  logic [LEN_BITS-1:0]  feat_q, feat_d;
  logic [PT_BITS:0]     rem_q, rem_d;
  logic                 rst_q;

  // Metadata travelling alongside the read in flight
  logic                 inflight_q;
  logic [PT_BITS-1:0]   if_pt_q;
  logic [LEN_BITS-1:0]  if_feat_q;
  logic                 if_eop_q;
  logic                 if_last_q;

  // Two-entry output FIFO; entry 0 is the head
  entry_t               ent0_q, ent1_q;
  logic                 v0_q, v1_q;

  logic                 accept;
  logic                 issue;
  logic                 pop;
  logic                 push;
  logic [1:0]           occ;
  logic [1:0]           occ_left;
  logic [1:0]           credit_used;
  logic                 is_eop;
  logic                 is_last;
  entry_t               new_ent;

  // rd_ready stays low for the cycle following a reset edge
  assign rd_ready = (state_q == S_IDLE) && !rst_q;
  assign accept   = rd_req && rd_ready;

  assign pop         = v0_q && out_ready;
  assign push        = inflight_q;
  assign occ         = {1'b0, v0_q} + {1'b0, v1_q};
  assign occ_left    = occ - {1'b0, pop};
  // A word leaving the FIFO this cycle frees its slot for a new issue
  assign credit_used = occ_left + {1'b0, inflight_q};
  assign issue       = (state_q == S_RUN) && (credit_used < 2'd2);

  assign is_eop  = (feat_q == FEAT_LAST);
  assign is_last = is_eop && (rem_q == REM_ONE);

  assign new_ent = '{data: rdata_q, pt: if_pt_q, feat: if_feat_q,
                     eop: if_eop_q, last: if_last_q};

  assign out_valid = v0_q;
  assign out_data  = ent0_q.data;
  assign out_pt    = ent0_q.pt;
  assign out_feat  = ent0_q.feat;
  assign out_eop   = ent0_q.eop;
  assign out_last  = ent0_q.last;

  always_comb begin
    state_d = state_q;
    pt_d    = pt_q;
    feat_d  = feat_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          pt_d   = rd_pt;
          feat_d = '0;
          rem_d  = rd_num;
          if (rd_num != '0) state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (issue) begin
          feat_d = feat_q + 1'b1;
          if (is_eop) begin
            pt_d  = pt_q + 1'b1;
            rem_d = rem_q - 1'b1;
            if (rem_q == REM_ONE) state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Leave as the final word transfers, so a new request can follow at once
        if (!inflight_q && (occ_left == 2'd0)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read-first: the read samples the array before this edge's write lands
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[{wr_pt, wr_feat}] <= wr_data;
    if (issue) rdata_q <= mem_q[{pt_q, feat_q}];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pt_q       <= '0;
      feat_q     <= '0;
      rem_q      <= '0;
      rst_q      <= 1'b1;
      inflight_q <= 1'b0;
      if_pt_q    <= '0;
      if_feat_q  <= '0;
      if_eop_q   <= 1'b0;
      if_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pt_q       <= pt_d;
      feat_q     <= feat_d;
      rem_q      <= rem_d;
      rst_q      <= 1'b0;
      inflight_q <= issue;
      if (issue) begin
        if_pt_q   <= pt_q;
        if_feat_q <= feat_q;
        if_eop_q  <= is_eop;
        if_last_q <= is_last;
      end
    end
  end

  // The issue rule guarantees a free slot whenever push is asserted
  always_ff @(posedge clk) begin
    if (rst) begin
      ent0_q <= '0;
      ent1_q <= '0;
      v0_q   <= 1'b0;
      v1_q   <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (!v0_q) begin
            ent0_q <= new_ent;
            v0_q   <= 1'b1;
          end else begin
            ent1_q <= new_ent;
            v1_q   <= 1'b1;
          end
        end
        2'b01: begin
          if (v1_q) ent0_q <= ent1_q;
          v0_q <= v1_q;
          v1_q <= 1'b0;
        end
        2'b11: begin
          if (v1_q) begin
            ent0_q <= ent1_q;
            ent1_q <= new_ent;
          end else begin
            ent0_q <= new_ent;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_feature_mem_stream.sv
module tb_feature_mem_stream;

  localparam int DW     = 32;
  localparam int DEPTH  = 1024;
  localparam int LENGTH = 16;
  localparam int PTB    = 10;
  localparam int LB     = 4;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [PTB-1:0] wr_pt;
  logic [LB-1:0]  wr_feat;
  logic [DW-1:0]  wr_data;
  logic          rd_req;
  logic          rd_ready;
  logic [PTB-1:0] rd_pt;
  logic [PTB:0]   rd_num;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0]  out_data;
  logic [PTB-1:0] out_pt;
  logic [LB-1:0]  out_feat;
  logic          out_eop;
  logic          out_last;

  feature_mem_stream #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .LENGTH    (LENGTH),
    .PT_BITS   (PTB),
    .LEN_BITS  (LB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_pt    (wr_pt),
    .wr_feat  (wr_feat),
    .wr_data  (wr_data),
    .rd_req   (rd_req),
    .rd_ready (rd_ready),
    .rd_pt    (rd_pt),
    .rd_num   (rd_num),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_pt   (out_pt),
    .out_feat (out_feat),
    .out_eop  (out_eop),
    .out_last (out_last)
  );

  typedef struct packed {
    logic [DW-1:0]  data;
    logic [PTB-1:0] pt;
    logic [LB-1:0]  feat;
    logic           eop;
    logic           last;
  } word_t;

  typedef struct {
    int          pt;
    int          num;
    bit          stall;
    int          exp_words;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } vec_t;

  word_t       sb[$];
  logic [DW-1:0] model [DEPTH*LENGTH];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;

  // Monitor-side bookkeeping
  int          words_done;
  bit          got_last;
  int          last_xfer_cyc;
  bit          seen_lastv;
  int          first_last_cyc;
  logic [DW-1:0] first_data;
  logic [DW-1:0] last_data;
  logic [DW-1:0] cap_56;
  bit          prev_stall;
  word_t       snap;

  bit          stall_en;
  bit          force_low;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Consumer handshake driver
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (force_low)     out_ready = 1'b0;
      else if (stall_en) out_ready = 1'($urandom_range(0, 1));
      else               out_ready = 1'b1;
    end
  end

  // Monitor: values are settled at the falling edge; a valid&ready seen
  // here transfers at the next rising edge.
  initial forever begin
    word_t cur;
    word_t expw;
    @(negedge clk);
    cur = '{data: out_data, pt: out_pt, feat: out_feat, eop: out_eop, last: out_last};
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("stall_hold", 64'({out_valid, cur}), 64'({1'b1, snap}));
      if (out_valid && !out_ready) begin
        prev_stall = 1'b1;
        snap       = cur;
      end else begin
        prev_stall = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got pt=%0d feat=%0d data=0x%0h expected no word",
                   out_pt, out_feat, out_data);
        end else begin
          expw = sb.pop_front();
          chk("word", 64'(cur), 64'(expw));
        end
        if (words_done == 0) first_data = out_data;
        last_data = out_data;
        words_done++;
        if (out_pt == 10'd5 && out_feat == 4'd6) cap_56 = out_data;
        if (out_last) begin
          got_last      = 1'b1;
          last_xfer_cyc = cyc;
        end
      end
      if (out_valid && out_last && !seen_lastv) begin
        seen_lastv     = 1'b1;
        first_last_cyc = cyc;
      end
    end
  end

  task automatic push_expected(input int pt, input int num);
    for (int p = 0; p < num; p++) begin
      for (int f = 0; f < LENGTH; f++) begin
        int    ptv;
        word_t w;
        ptv    = (pt + p) % DEPTH;
        w.data = model[ptv*LENGTH + f];
        w.pt   = PTB'(ptv);
        w.feat = LB'(f);
        w.eop  = (f == LENGTH - 1);
        w.last = (p == num - 1) && (f == LENGTH - 1);
        sb.push_back(w);
      end
    end
  endtask

  // coll_at >= 0: write 0xDEAD to (pt, coll_at) in the cycle that word is read.
  // ign: hold a second request while the burst is busy.
  task automatic run_burst(input int pt, input int num, input bit stall,
                           input int coll_at, input bit ign);
    int acc;
    bit done;
    push_expected(pt, num);
    words_done = 0;
    got_last   = 1'b0;
    seen_lastv = 1'b0;
    stall_en   = stall;
    chk("rd_ready_before_req", 64'(rd_ready), 64'(1));
    rd_req = 1'b1;
    rd_pt  = PTB'(pt);
    rd_num = (PTB+1)'(num);
    step();
    rd_req = 1'b0;
    acc    = cyc;
    if (num == 0) begin
      chk("zero_len_ready", 64'(rd_ready), 64'(1));
      for (int k = 0; k < 3; k++) begin
        chk("zero_len_no_valid", 64'(out_valid), 64'(0));
        step();
      end
      stall_en = 1'b0;
      return;
    end
    done = 1'b0;
    for (int s = 1; s <= num*LENGTH*4 + 40; s++) begin
      if (s - 1 == coll_at) begin
        wr_en   = 1'b1;
        wr_pt   = PTB'(pt);
        wr_feat = LB'(coll_at);
        wr_data = 32'hDEAD;
      end
      if (ign && s - 1 >= 1 && s - 1 <= 4) begin
        rd_req = 1'b1;
        rd_pt  = 10'd40;
        rd_num = 11'd1;
      end
      step();
      rd_req = 1'b0;
      if (wr_en) begin
        wr_en = 1'b0;
        model[pt*LENGTH + coll_at] = 32'hDEAD;
      end
      if (s == 1) chk("lat_e1_valid", 64'(out_valid), 64'(0));
      if (s == 2) chk("lat_e2_valid", 64'(out_valid), 64'(1));
      if (ign && s == 2) chk("busy_ready_low", 64'(rd_ready), 64'(0));
      if (got_last && cyc == last_xfer_cyc + 1) begin
        chk("ready_after_last", 64'(rd_ready), 64'(1));
        if (!stall)
          chk("last_word_timing", 64'(first_last_cyc - acc), 64'(num*LENGTH + 1));
        done = 1'b1;
        break;
      end
    end
    stall_en = 1'b0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL burst_timeout: pt=%0d num=%0d got %0d words, out_last never transferred",
               pt, num, words_done);
    end
    chk("sb_empty", 64'(sb.size()), 64'(0));
    sb.delete();
  endtask

  vec_t vecs[5];

  initial begin
    int k;
    vecs[0] = '{pt: 3,    num: 2, stall: 1'b0, exp_words: 32,  exp_first: 32'd48,    exp_last: 32'd79};
    vecs[1] = '{pt: 1023, num: 2, stall: 1'b0, exp_words: 32,  exp_first: 32'd16368, exp_last: 32'd15};
    vecs[2] = '{pt: 0,    num: 1, stall: 1'b0, exp_words: 16,  exp_first: 32'd0,     exp_last: 32'd15};
    vecs[3] = '{pt: 5,    num: 8, stall: 1'b1, exp_words: 128, exp_first: 32'd80,    exp_last: 32'd207};
    vecs[4] = '{pt: 100,  num: 0, stall: 1'b0, exp_words: 0,   exp_first: 32'd0,     exp_last: 32'd0};

    rst       = 1'b1;
    wr_en     = 1'b0;
    wr_pt     = '0;
    wr_feat   = '0;
    wr_data   = '0;
    rd_req    = 1'b0;
    rd_pt     = '0;
    rd_num    = '0;
    stall_en  = 1'b0;
    force_low = 1'b0;
    words_done = 0;

    // Power-up reset
    step();
    step();
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_data",  64'(out_data),  64'(0));
    chk("rst_meta",  64'({out_pt, out_feat, out_eop, out_last}), 64'(0));
    chk("rst_ready", 64'(rd_ready),  64'(0));
    rst = 1'b0;
    step();
    chk("ready_after_rst", 64'(rd_ready), 64'(1));

    // Fill every word with pt*16+feat
    for (int p = 0; p < DEPTH; p++) begin
      for (int f = 0; f < LENGTH; f++) begin
        wr_en   = 1'b1;
        wr_pt   = PTB'(p);
        wr_feat = LB'(f);
        wr_data = DW'(p*LENGTH + f);
        model[p*LENGTH + f] = DW'(p*LENGTH + f);
        step();
      end
    end
    wr_en = 1'b0;

    // Table-driven bursts, issued back to back
    foreach (vecs[i]) begin
      run_burst(vecs[i].pt, vecs[i].num, vecs[i].stall, -1, 1'b0);
      chk("vec_words", 64'(words_done), 64'(vecs[i].exp_words));
      if (vecs[i].exp_words > 0) begin
        chk("vec_first", 64'(first_data), 64'(vecs[i].exp_first));
        chk("vec_last",  64'(last_data),  64'(vecs[i].exp_last));
      end
    end

    // Request held during a busy burst is ignored
    run_burst(20, 2, 1'b0, -1, 1'b1);
    chk("ignored_req_words", 64'(words_done), 64'(32));
    for (int j = 0; j < 4; j++) begin
      step();
      chk("ignored_req_idle", 64'(out_valid), 64'(0));
    end

    // Write/read collision on (5,6): stream sees old value, next burst the new one
    run_burst(5, 1, 1'b0, 6, 1'b0);
    chk("collision_old", 64'(cap_56), 64'(86));
    run_burst(5, 1, 1'b0, -1, 1'b0);
    chk("collision_new", 64'(cap_56), 64'(32'hDEAD));

    // Reset in the middle of a 4-point burst
    push_expected(0, 4);
    words_done = 0;
    got_last   = 1'b0;
    rd_req = 1'b1;
    rd_pt  = '0;
    rd_num = 11'd4;
    step();
    rd_req = 1'b0;
    k = 0;
    while (words_done < 5 && k < 40) begin
      step();
      k++;
    end
    chk("reset_test_words_before", 64'(words_done), 64'(5));
    rst       = 1'b1;
    force_low = 1'b1;
    sb.delete();
    step();
    chk("midrst_valid", 64'(out_valid), 64'(0));
    chk("midrst_data",  64'(out_data),  64'(0));
    chk("midrst_meta",  64'({out_pt, out_feat, out_eop, out_last}), 64'(0));
    chk("midrst_ready", 64'(rd_ready),  64'(0));
    rst       = 1'b0;
    force_low = 1'b0;
    step();
    chk("midrst_ready_next", 64'(rd_ready),  64'(1));
    chk("midrst_no_stale",   64'(out_valid), 64'(0));
    run_burst(7, 1, 1'b0, -1, 1'b0);
    chk("post_rst_words", 64'(words_done), 64'(16));
    chk("post_rst_first", 64'(first_data), 64'(112));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
